// File: rtl/tx_stream_arb.sv
`default_nettype none
// ============================================================================
// Module      : tx_stream_arb
// Description : Two-port, packet-granular AXI-Stream arbiter feeding a shared
//               10G MAC TX stream. Requester 0 carries upstream-TLP frames and
//               requester 1 carries downstream-TLP frames. Once a port is
//               granted, its stream passes through combinationally until its
//               tlast handshake. Every frame is followed by one idle cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   CNT_W               width of each per-port frame counter (wraps)
// Ports:
//   clk156              single clock, rising edge
//   sys_rst_n           synchronous active-low reset
//   s0_axis_*           requester 0 stream (tvalid/tready/tdata/tkeep/tlast/tuser)
//   s1_axis_*           requester 1 stream (same layout)
//   m_axis_*            shared MAC TX stream
//   grant               one-hot owner of m_axis (01=s0, 10=s1, 00=idle)
//   pkt_cnt0/pkt_cnt1   frames forwarded from port 0 / port 1
// Configuration macro:
//   TX_STREAM_ARB_PRIO_EN  defined   -> strict priority, port 0 first
//                          undefined -> round-robin (default)
// ============================================================================
module tx_stream_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk156,
  input  logic             sys_rst_n,

  input  logic             s0_axis_tvalid,
  output logic             s0_axis_tready,
  input  logic [63:0]      s0_axis_tdata,
  input  logic [7:0]       s0_axis_tkeep,
  input  logic             s0_axis_tlast,
  input  logic             s0_axis_tuser,

  input  logic             s1_axis_tvalid,
  output logic             s1_axis_tready,
  input  logic [63:0]      s1_axis_tdata,
  input  logic [7:0]       s1_axis_tkeep,
  input  logic             s1_axis_tlast,
  input  logic             s1_axis_tuser,

  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,

  output logic [1:0]       grant,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_S0   = 2'd1,
    ARB_S1   = 2'd2
  } arb_state_t;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

  // Frame-completing beat of the granted port.
  logic s0_done;
  logic s1_done;
  logic pick_s1;

  assign s0_done = (state_q == ARB_S0) & s0_axis_tvalid & m_axis_tready & s0_axis_tlast;
  assign s1_done = (state_q == ARB_S1) & s1_axis_tvalid & m_axis_tready & s1_axis_tlast;

`ifdef TX_STREAM_ARB_PRIO_EN
  // Strict priority: port 1 only wins when port 0 is silent.
  assign pick_s1 = ~s0_axis_tvalid;
`else
  // Round-robin: last_gnt_q holds the port of the last completed frame
  // (0 = port 0, 1 = port 1). On contention the other port wins.
  logic last_gnt_q, last_gnt_d;

  assign pick_s1 = s1_axis_tvalid & (~s0_axis_tvalid | ~last_gnt_q);

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (s0_done) last_gnt_d = 1'b0;
    if (s1_done) last_gnt_d = 1'b1;
  end

  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      last_gnt_q <= 1'b1;  // port 0 wins the first contention
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // Next state, counters and datapath steering.
  always_comb begin
    state_d        = state_q;
    pkt_cnt0_d     = pkt_cnt0_q;
    pkt_cnt1_d     = pkt_cnt1_q;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = 64'd0;
    m_axis_tkeep   = 8'd0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    grant          = 2'b00;

    if (s0_done) pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
    if (s1_done) pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);

    case (state_q)
      ARB_IDLE: begin
        if (s0_axis_tvalid | s1_axis_tvalid) begin
          state_d = pick_s1 ? ARB_S1 : ARB_S0;
        end
      end
      ARB_S0: begin
        if (s0_done) state_d = ARB_IDLE;
      end
      ARB_S1: begin
        if (s1_done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Outputs are forced quiet while reset is held, even before the
    // reset edge has returned the state register to idle.
    if (sys_rst_n) begin
      case (state_q)
        ARB_S0: begin
          m_axis_tvalid  = s0_axis_tvalid;
          m_axis_tdata   = s0_axis_tdata;
          m_axis_tkeep   = s0_axis_tkeep;
          m_axis_tlast   = s0_axis_tlast;
          m_axis_tuser   = s0_axis_tuser;
          s0_axis_tready = m_axis_tready;
          grant          = 2'b01;
        end
        ARB_S1: begin
          m_axis_tvalid  = s1_axis_tvalid;
          m_axis_tdata   = s1_axis_tdata;
          m_axis_tkeep   = s1_axis_tkeep;
          m_axis_tlast   = s1_axis_tlast;
          m_axis_tuser   = s1_axis_tuser;
          s1_axis_tready = m_axis_tready;
          grant          = 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      state_q    <= ARB_IDLE;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_stream_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_stream_arb
// Description : Directed self-checking bench for tx_stream_arb (CNT_W=4 so the
//               counter wrap is reachable). Expected frame order follows the
//               TX_STREAM_ARB_PRIO_EN build setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_stream_arb;

  localparam int CNT_W = 4;

  logic             clk156 = 1'b0;
  logic             sys_rst_n;
  logic             s0_axis_tvalid, s0_axis_tready;
  logic [63:0]      s0_axis_tdata;
  logic [7:0]       s0_axis_tkeep;
  logic             s0_axis_tlast, s0_axis_tuser;
  logic             s1_axis_tvalid, s1_axis_tready;
  logic [63:0]      s1_axis_tdata;
  logic [7:0]       s1_axis_tkeep;
  logic             s1_axis_tlast, s1_axis_tuser;
  logic             m_axis_tvalid, m_axis_tready;
  logic [63:0]      m_axis_tdata;
  logic [7:0]       m_axis_tkeep;
  logic             m_axis_tlast, m_axis_tuser;
  logic [1:0]       grant;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  always #5 clk156 = ~clk156;

  tx_stream_arb #(.CNT_W(CNT_W)) dut (
    .clk156         (clk156),
    .sys_rst_n      (sys_rst_n),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tkeep  (s0_axis_tkeep),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tuser  (s0_axis_tuser),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tkeep  (s1_axis_tkeep),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tuser  (s1_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .grant          (grant),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
  );

  int checks = 0;
  int passes = 0;

  // Expected frame order on m_axis, filled in by each test.
  int exp_port [0:31];
  int exp_n;
  int first_cyc;
  bit mon_done;

  function automatic logic [63:0] beat_data(input int p, input int f, input int b);
    return {8'(p), 8'(f), 8'(b), 40'h5A5AC3C30F};
  endfunction

  task automatic drive(input int p, input logic v, input int f, input int b, input int len);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l, u;
    d = '0; k = '0; l = 1'b0; u = 1'b0;
    if (v) begin
      d = beat_data(p, f, b);
      k = (b == len - 1) ? 8'h0F : 8'hFF;
      l = (b == len - 1);
      u = (b == 0);
    end
    if (p == 0) begin
      s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tkeep = k;
      s0_axis_tlast  = l; s0_axis_tuser = u;
    end else begin
      s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tkeep = k;
      s1_axis_tlast  = l; s1_axis_tuser = u;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? s0_axis_tready : s1_axis_tready;
  endfunction

  // Source: sends nfr frames of len beats; optional 3-cycle stall before
  // beat stall_beat of the first frame. Always called at posedge+1.
  task automatic src(input int p, input int nfr, input int len, input int stall_beat, input int dly);
    int tmo;
    repeat (dly) begin @(posedge clk156); #1; end
    for (int f = 0; f < nfr; f++) begin
      for (int b = 0; b < len; b++) begin
        if (f == 0 && b == stall_beat) begin
          drive(p, 1'b0, 0, 0, len);
          for (int s = 0; s < 3; s++) begin
            @(negedge clk156);
            checks++;
            if (grant !== 2'b01 || m_axis_tvalid !== 1'b0 || s1_axis_tready !== 1'b0)
              $display("FAIL stall cyc%0d: grant=%b m_tvalid=%b s1_tready=%b, want 01/0/0",
                       s, grant, m_axis_tvalid, s1_axis_tready);
            else passes++;
            @(posedge clk156); #1;
          end
        end
        drive(p, 1'b1, f, b, len);
        tmo = 0;
        do begin @(negedge clk156); tmo++; end while (!rdy(p) && tmo < 400);
        @(posedge clk156); #1;
      end
    end
    drive(p, 1'b0, 0, 0, len);
  endtask

  // Monitor: checks every m_axis beat against the expected frame order,
  // and the idle bubble after every tlast.
  task automatic monitor(input int len, input int budget);
    int fi, bi, cyc, p;
    int fcnt [0:1];
    bit after_last;
    logic [74:0] exp_v, got_v;
    fi = 0; bi = 0; cyc = 0; after_last = 0;
    fcnt[0] = 0; fcnt[1] = 0;
    first_cyc = -1;
    mon_done = 0;
    while ((fi < exp_n || after_last) && cyc < budget) begin
      @(negedge clk156);
      if (after_last) begin
        checks++;
        if (grant !== 2'b00 || m_axis_tvalid !== 1'b0)
          $display("FAIL bubble frame%0d: grant=%b m_tvalid=%b, want 00/0", fi - 1, grant, m_axis_tvalid);
        else passes++;
        after_last = 0;
      end else if (m_axis_tvalid && m_axis_tready) begin
        p = exp_port[fi];
        if (first_cyc < 0) first_cyc = cyc;
        exp_v = {(p == 0) ? 2'b01 : 2'b10, beat_data(p, fcnt[p], bi),
                 (bi == len - 1) ? 8'h0F : 8'hFF, bi == len - 1, bi == 0};
        got_v = {grant, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        checks++;
        if (got_v !== exp_v)
          $display("FAIL beat f%0d b%0d: got %h want %h", fi, bi, got_v, exp_v);
        else passes++;
        if (bi == len - 1) begin
          bi = 0; fcnt[p]++; fi++; after_last = 1;
        end else bi++;
      end
      cyc++;
    end
    if (fi < exp_n) begin
      checks++;
      $display("FAIL monitor timeout: got %0d frames, want %0d", fi, exp_n);
    end
    mon_done = 1;
  endtask

  task automatic toggle_ready();
    int c;
    c = 0;
    while (!mon_done && c < 400) begin
      @(posedge clk156); #1;
      m_axis_tready = ~m_axis_tready;
      c++;
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic watch_s0();
    int c;
    c = 0;
    while (!mon_done && c < 400) begin
      @(negedge clk156);
      if (grant !== 2'b01) begin
        checks++;
        if (s0_axis_tready !== 1'b0)
          $display("FAIL s0_tready while not granted: got %b want 0 (grant=%b)", s0_axis_tready, grant);
        else passes++;
      end
      c++;
    end
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1);
    checks++;
    if (pkt_cnt0 !== c0 || pkt_cnt1 !== c1)
      $display("FAIL %s counters: got %0d/%0d want %0d/%0d", name, pkt_cnt0, pkt_cnt1, c0, c1);
    else passes++;
  endtask

  task automatic apply_reset();
    @(posedge clk156); #1;
    sys_rst_n = 1'b0;
    m_axis_tready = 1'b0;
    drive(0, 1'b0, 0, 0, 1);
    drive(1, 1'b0, 0, 0, 1);
    repeat (2) @(posedge clk156);
    #1 sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    m_axis_tready = 1'b1;
    drive(0, 1'b1, 0, 0, 2);
    drive(1, 1'b1, 0, 0, 2);
    repeat (2) @(posedge clk156);
    @(negedge clk156);
    checks++;
    if (grant !== 2'b00 || m_axis_tvalid !== 1'b0 || s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0)
      $display("FAIL reset held: grant=%b m_tvalid=%b rdy=%b%b, want 00/0/00",
               grant, m_axis_tvalid, s0_axis_tready, s1_axis_tready);
    else passes++;
    check_cnt("reset", 0, 0);
    @(posedge clk156); #1;
    drive(0, 1'b0, 0, 0, 2);
    drive(1, 1'b0, 0, 0, 2);
    sys_rst_n = 1'b1;
    @(negedge clk156);
    checks++;
    if ({grant, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== 77'd0)
      $display("FAIL idle outputs: grant=%b tvalid=%b tdata=%h tkeep=%h, want all 0",
               grant, m_axis_tvalid, m_axis_tdata, m_axis_tkeep);
    else passes++;
  endtask

  task automatic test_single();
    apply_reset();
    m_axis_tready = 1'b1;
    exp_n = 1; exp_port[0] = 0;
    fork
      src(0, 1, 7, -1, 0);
      monitor(7, 60);
    join
    checks++;
    if (first_cyc !== 1) $display("FAIL grant latency: got %0d want 1", first_cyc);
    else passes++;
    check_cnt("single", 1, 0);
  endtask

  task automatic test_contention();
    apply_reset();
    m_axis_tready = 1'b1;
    exp_n = 6;
`ifdef TX_STREAM_ARB_PRIO_EN
    for (int i = 0; i < 6; i++) exp_port[i] = (i < 3) ? 0 : 1;
`else
    for (int i = 0; i < 6; i++) exp_port[i] = i % 2;
`endif
    fork
      src(0, 3, 7, -1, 0);
      src(1, 3, 7, -1, 0);
      monitor(7, 200);
    join
    check_cnt("contention", 3, 3);
  endtask

  task automatic test_backpressure();
    apply_reset();
    m_axis_tready = 1'b1;
    exp_n = 2; exp_port[0] = 1; exp_port[1] = 0;
    mon_done = 0;
    fork
      src(1, 1, 7, -1, 0);
      src(0, 1, 7, -1, 3);
      monitor(7, 200);
      toggle_ready();
      watch_s0();
    join
    check_cnt("backpressure", 1, 1);
  endtask

  task automatic test_stall();
    apply_reset();
    m_axis_tready = 1'b1;
    exp_n = 2; exp_port[0] = 0; exp_port[1] = 1;
    fork
      src(0, 1, 7, 3, 0);
      src(1, 1, 7, -1, 0);
      monitor(7, 200);
    join
    check_cnt("stall", 1, 1);
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    m_axis_tready = 1'b1;
    exp_n = 17;
    for (int i = 0; i < 17; i++) exp_port[i] = 0;
    fork
      src(0, 17, 2, -1, 0);
      monitor(2, 200);
    join
    check_cnt("wrap", 1, 0);
    // Start a frame and reset it after the first beat.
    @(posedge clk156); #1;
    drive(0, 1'b1, 0, 0, 7);
    @(posedge clk156); #1;
    @(negedge clk156);
    checks++;
    if (grant !== 2'b01 || s0_axis_tready !== 1'b1)
      $display("FAIL midframe grant: grant=%b s0_tready=%b want 01/1", grant, s0_axis_tready);
    else passes++;
    @(posedge clk156); #1;
    drive(0, 1'b1, 0, 1, 7);
    sys_rst_n = 1'b0;
    @(negedge clk156);
    checks++;
    if (grant !== 2'b00 || m_axis_tvalid !== 1'b0 || s0_axis_tready !== 1'b0)
      $display("FAIL during reset: grant=%b m_tvalid=%b s0_tready=%b want 00/0/0",
               grant, m_axis_tvalid, s0_axis_tready);
    else passes++;
    @(posedge clk156); #1;
    sys_rst_n = 1'b1;
    drive(0, 1'b0, 0, 0, 7);
    @(negedge clk156);
    checks++;
    if (grant !== 2'b00 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0)
      $display("FAIL after reset: grant=%b m_tvalid=%b m_tlast=%b want 00/0/0",
               grant, m_axis_tvalid, m_axis_tlast);
    else passes++;
    check_cnt("after reset", 0, 0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    m_axis_tready = 1'b0;
    exp_n = 0;
    first_cyc = -1;
    mon_done = 0;
    drive(0, 1'b0, 0, 0, 1);
    drive(1, 1'b0, 0, 0, 1);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_stall();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
